// File: rtl/systolic_pkg.sv
// Shared types for the systolic array edge feeders: FSM state encoding and lane payload.
package systolic_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2,
    DONE   = 2'd3
  } feeder_state_t;

  typedef struct packed {
    logic                     active;
    logic [DEFAULT_WIDTH-1:0] data;
  } lane_t;

endpackage

// File: rtl/systolic_skew_delay_line.sv
// Fixed-depth shift register for one skew lane; synchronous active-low clear empties every stage.
module skew_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 17
) (
  input  logic             clk_i,
  input  logic             clr_n_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (!clr_n_i) begin
      for (int k = 0; k < DEPTH; k++) stage_q[k] <= '0;
    end else begin
      stage_q[0] <= din_i;
      for (int k = 1; k < DEPTH; k++) stage_q[k] <= stage_q[k-1];
    end
  end

  assign dout_o = stage_q[DEPTH-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Diagonal-wavefront feeder: lane i delayed i+1 cycles, N-1 zero flush beats, then a done pulse.
// States: IDLE wait start | STREAM accept slices | FLUSH push zeros | DONE one-cycle pulse.
// Optional sticky underrun flag built only when FEEDER_UNDERRUN_CHECK_EN is defined.
module systolic_skew_feeder
  import systolic_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  parameter  int N     = 4,
  parameter  int K_MAX = 16,
  localparam int KW    = $clog2(K_MAX + 1)
) (
  input  logic             clock,
  input  logic             nreset,
  input  logic             start,
  input  logic [KW-1:0]    k_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N*WIDTH-1:0] out_data,
  output logic [N-1:0]     out_active,
  output logic             busy,
  output logic             done,
  output logic             err_underrun
);

  localparam int FW = (N > 1) ? $clog2(N) : 1;

  feeder_state_t state_q, state_d;
  logic [KW-1:0] remain_q, remain_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [KW-1:0] k_sat;
  logic          accept;

  assign k_sat  = (k_len > KW'(K_MAX)) ? KW'(K_MAX) : k_len;
  assign accept = (state_q == STREAM) && in_valid;

  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    fcnt_d   = fcnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          remain_d = k_sat;
          state_d  = (k_sat == '0) ? DONE : STREAM;
        end
      end
      STREAM: begin
        if (in_valid) begin
          remain_d = remain_q - KW'(1);
          if (remain_q == KW'(1)) begin
            if (N == 1) begin
              state_d = DONE;
            end else begin
              state_d = FLUSH;
              fcnt_d  = FW'(N - 1);
            end
          end
        end
      end
      FLUSH: begin
        if (fcnt_q <= FW'(1)) state_d = DONE;
        else                  fcnt_d  = fcnt_q - FW'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!nreset) begin
      state_q  <= IDLE;
      remain_q <= '0;
      fcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      fcnt_q   <= fcnt_d;
    end
  end

  assign in_ready = (state_q == STREAM);
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);

`ifdef FEEDER_UNDERRUN_CHECK_EN
  logic err_q;
  always_ff @(posedge clock) begin
    if (!nreset)                              err_q <= 1'b0;
    else if ((state_q == IDLE) && start)      err_q <= 1'b0;
    else if ((state_q == STREAM) && !in_valid) err_q <= 1'b1;
  end
  assign err_underrun = err_q;
`else
  assign err_underrun = 1'b0;
`endif

  // Non-accepted slots carry {0,0} so bubbles and flush beats are inert in the PE grid.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [WIDTH:0] lane_in, lane_out;
    assign lane_in = accept ? {1'b1, in_data[i*WIDTH +: WIDTH]} : '0;
    skew_delay_line #(
      .DEPTH(i + 1),
      .WIDTH(WIDTH + 1)
    ) u_delay (
      .clk_i  (clock),
      .clr_n_i(nreset),
      .din_i  (lane_in),
      .dout_o (lane_out)
    );
    assign out_active[i]              = lane_out[WIDTH];
    assign out_data[i*WIDTH +: WIDTH] = lane_out[WIDTH-1:0];
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder with N=4, WIDTH=16, K_MAX=16.
module tb_systolic_skew_feeder;

  localparam int KW = 5;

`ifdef FEEDER_UNDERRUN_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          nreset, start, in_valid;
  logic [KW-1:0] k_len;
  logic [63:0]   in_data;
  logic          in_ready, busy, done, err_underrun;
  logic [63:0]   out_data;
  logic [3:0]    out_active;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  systolic_skew_feeder #(.WIDTH(16), .N(4), .K_MAX(16)) dut (
    .clock       (clock),
    .nreset      (nreset),
    .start       (start),
    .k_len       (k_len),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_data    (out_data),
    .out_active  (out_active),
    .busy        (busy),
    .done        (done),
    .err_underrun(err_underrun)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic [63:0] d);
    in_valid = v;
    in_data  = d;
    @(posedge clock);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [63:0] d, input logic [3:0] a, input logic dn);
    chk({tag, "_data"}, out_data, d);
    chk({tag, "_act"}, {60'd0, out_active}, {60'd0, a});
    chk({tag, "_done"}, {63'd0, done}, {63'd0, dn});
  endtask

  initial begin
    logic [15:0] v;

    // reset held with start and in_valid asserted
    nreset = 1'b0; start = 1'b1; in_valid = 1'b1; k_len = 5'd3;
    in_data = 64'h1234_5678_9ABC_DEF0;
    repeat (3) begin
      @(posedge clock); #1;
      chk("rst_busy", {63'd0, busy}, 64'd0);
    end
    chk_out("rst", 64'd0, 4'b0000, 1'b0);
    chk("rst_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_err", {63'd0, err_underrun}, 64'd0);

    nreset = 1'b1; start = 1'b0;
    step(1'b1, 64'h1111_2222_3333_4444);
    chk("idle_busy", {63'd0, busy}, 64'd0);
    chk("idle_ready", {63'd0, in_ready}, 64'd0);
    chk_out("idle_ignored", 64'd0, 4'b0000, 1'b0);

    // basic gap-free run; stray start mid-stream with a larger k_len
    start = 1'b1; k_len = 5'd3; in_valid = 1'b0;
    @(posedge clock); #1;
    start = 1'b0;
    chk("b0_busy", {63'd0, busy}, 64'd1);
    chk("b0_ready", {63'd0, in_ready}, 64'd1);
    step(1'b1, 64'h0004_0003_0002_0001);
    chk_out("b1", 64'h0000_0000_0000_0001, 4'b0001, 1'b0);
    start = 1'b1; k_len = 5'd7;
    step(1'b1, 64'h0008_0007_0006_0005);
    start = 1'b0;
    chk_out("b2", 64'h0000_0000_0002_0005, 4'b0011, 1'b0);
    step(1'b1, 64'h000C_000B_000A_0009);
    chk_out("b3", 64'h0000_0003_0006_0009, 4'b0111, 1'b0);
    chk("b3_ready", {63'd0, in_ready}, 64'd0);
    step(1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    chk_out("b4", 64'h0004_0007_000A_0000, 4'b1110, 1'b0);
    step(1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    chk_out("b5", 64'h0008_000B_0000_0000, 4'b1100, 1'b0);
    step(1'b0, 64'd0);
    chk_out("b6", 64'h000C_0000_0000_0000, 4'b1000, 1'b1);
    step(1'b0, 64'd0);
    chk_out("b7", 64'd0, 4'b0000, 1'b0);
    chk("b7_busy", {63'd0, busy}, 64'd0);

    // start in the cycle after done; one bubble after the first slice
    start = 1'b1; k_len = 5'd3;
    @(posedge clock); #1;
    start = 1'b0;
    chk("u0_busy", {63'd0, busy}, 64'd1);
    step(1'b1, 64'h0004_0003_0002_0001);
    chk_out("u1", 64'h0000_0000_0000_0001, 4'b0001, 1'b0);
    step(1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
    chk_out("u2", 64'h0000_0000_0002_0000, 4'b0010, 1'b0);
    chk("u2_err", {63'd0, err_underrun}, {63'd0, EXP_ERR});
    step(1'b1, 64'h0008_0007_0006_0005);
    chk_out("u3", 64'h0000_0003_0000_0005, 4'b0101, 1'b0);
    step(1'b1, 64'h000C_000B_000A_0009);
    chk_out("u4", 64'h0004_0000_0006_0009, 4'b1011, 1'b0);
    step(1'b0, 64'd0);
    chk_out("u5", 64'h0000_0007_000A_0000, 4'b0110, 1'b0);
    step(1'b0, 64'd0);
    chk_out("u6", 64'h0008_000B_0000_0000, 4'b1100, 1'b0);
    step(1'b0, 64'd0);
    chk_out("u7", 64'h000C_0000_0000_0000, 4'b1000, 1'b1);
    step(1'b0, 64'd0);
    chk_out("u8", 64'd0, 4'b0000, 1'b0);
    chk("u8_err_sticky", {63'd0, err_underrun}, {63'd0, EXP_ERR});

    // k_len above K_MAX saturates to 16 slices
    start = 1'b1; k_len = 5'd31;
    @(posedge clock); #1;
    start = 1'b0;
    chk("sat_err_clr", {63'd0, err_underrun}, 64'd0);
    for (int i = 0; i < 16; i++) begin
      v = 16'(i * 32'h1111);
      step(1'b1, {4{v}});
      chk("sat_lane0", {48'd0, out_data[15:0]}, {48'd0, v});
      chk("sat_ready", {63'd0, in_ready}, (i < 15) ? 64'd1 : 64'd0);
    end
    step(1'b0, 64'd0);
    chk("sat_f1_done", {63'd0, done}, 64'd0);
    step(1'b0, 64'd0);
    chk("sat_f2_done", {63'd0, done}, 64'd0);
    step(1'b0, 64'd0);
    chk("sat_done", {63'd0, done}, 64'd1);
    chk("sat_lane3", {48'd0, out_data[63:48]}, 64'hFFFF);
    step(1'b0, 64'd0);
    chk("sat_post_done", {63'd0, done}, 64'd0);

    // zero-length run
    start = 1'b1; k_len = 5'd0; in_valid = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    chk("z_done", {63'd0, done}, 64'd1);
    chk("z_ready", {63'd0, in_ready}, 64'd0);
    chk("z_busy", {63'd0, busy}, 64'd1);
    step(1'b1, 64'h0004_0003_0002_0001);
    chk_out("z1", 64'd0, 4'b0000, 1'b0);
    chk("z1_busy", {63'd0, busy}, 64'd0);

    // reset during FLUSH drops the run
    start = 1'b1; k_len = 5'd2;
    @(posedge clock); #1;
    start = 1'b0;
    step(1'b1, 64'h0004_0003_0002_0001);
    step(1'b1, 64'h0008_0007_0006_0005);
    chk("r_ready", {63'd0, in_ready}, 64'd0);
    chk("r_busy", {63'd0, busy}, 64'd1);
    step(1'b0, 64'd0);
    nreset = 1'b0;
    @(posedge clock); #1;
    nreset = 1'b1;
    chk_out("r_cleared", 64'd0, 4'b0000, 1'b0);
    chk("r_cleared_busy", {63'd0, busy}, 64'd0);
    repeat (4) begin
      step(1'b0, 64'd0);
      chk("r_no_done", {63'd0, done}, 64'd0);
      chk("r_no_act", {60'd0, out_active}, 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/systolic_skew_feeder.md
# systolic_skew_feeder

Upstream edge feeder for the systolic multiply array. Accepts one N-lane operand vector per cycle (one k-slice of a row-block of A or column-block of B) and emits it as a diagonal wavefront: lane i is delayed i+1 cycles, so operands meet correctly inside the processing-element grid. After the last slice it appends N-1 zero flush beats and pulses `done`. Zeros are safe because a zero operand adds nothing to a PE accumulator.

## Interface
- `WIDTH`, 16: operand width per lane.
- `N`, 4: array edge size; number of lanes.
- `K_MAX`, 16: maximum slices per run. `KW = $clog2(K_MAX+1)`.

Ports:
- `clock`  in  1  rising-edge clock.
- `nreset`  in  1  reset; synchronous, active-low.
- `start`  in  1  begin a run; sampled only in IDLE.
- `k_len`  in  KW  slices in this run, sampled with `start`; 0..K_MAX.
- `in_valid`  in  1  `in_data` holds a slice.
- `in_ready`  out  1  feeder accepts a slice this cycle.
- `in_data`  in  N*WIDTH  lane i in bits [i*WIDTH +: WIDTH].
- `out_data`  out  N*WIDTH  skewed lanes to the array edge, registered.
- `out_active`  out  N  lane i currently carries a real operand, not a bubble or flush value.
- `busy`  out  1  state is not IDLE.
- `done`  out  1  one-cycle pulse when the last operand is on lane N-1.
- `err_underrun`  out  1  sticky; see Configuration.

## Operation
States:
- IDLE. `in_ready`=0. On `start`, `remain` loads `k_len`. If `k_len`>0, go to STREAM. If `k_len`==0, go to DONE.
- STREAM. `in_ready`=1.
  - On an `in_valid` cycle, the slice enters the lane-0 input and `remain` decrements.
  - On a `!in_valid` cycle, a zero bubble enters, `out_active` stays low for that slot, and `remain` is unchanged.
  - When the beat that makes `remain` 0 is accepted, go to FLUSH with `fcnt`=N-1. If N==1, go to DONE instead.
- FLUSH. `in_ready`=0. Zeros enter for N-1 cycles, then go to DONE.
- DONE. `done`=1 for exactly one cycle, then go to IDLE.

Datapath rules:
- Each lane is a shift register of depth i+1 carrying {active, data}.
- The lane input is {1, in_data lane i} on an accepted beat, otherwise {0, 0}.
- No arithmetic is done on the data. Values pass through bit-exact; there is no width growth.

Boundary conditions:
- `start` outside IDLE is ignored.
- `start` in the cycle after DONE (state IDLE) is accepted normally.
- `k_len` > K_MAX saturates to K_MAX.
- `in_valid` outside STREAM is ignored; no data is consumed.
- Reset mid-run returns to IDLE, clears all delay stages, and drops any partial run.

## Timing
- Reset values: `in_ready`=0, `out_data`=0, `out_active`=0, `busy`=0, `done`=0, `err_underrun`=0, state IDLE.
- `start` at edge s: the state is STREAM from cycle s+1, and `in_ready`=1 from that cycle.
- A beat accepted at edge t appears on lane i during cycle t+i+1.
- Last beat accepted at edge L:
  - FLUSH occupies cycles L+1 .. L+N-1.
  - DONE occupies cycle L+N, which coincides with lane N-1 showing the last operand.
- Run length for a gap-free stream: 1 + k_len + N cycles from `start` to the `done` pulse.

## Configuration
- `FEEDER_UNDERRUN_CHECK_EN` defined:
  - `err_underrun` sets on any STREAM cycle with `in_valid`=0.
  - It clears on an accepted `start`; it does not clear on `done`.
  - Reset clears it.
- Not defined: `err_underrun` is tied to 0 and the detection logic is absent. Bubble behaviour is unchanged.

## Structure
- Shared package `systolic_pkg`:
  - `WIDTH` default.
  - `feeder_state_t` enum {IDLE, STREAM, FLUSH, DONE}.
  - `lane_t` struct {active, data}.
- Sub-module `skew_delay_line`:
  - Parameters: `DEPTH`, `WIDTH`.
  - Synchronous active-low clear; one instance per lane with `DEPTH`=i+1.
  - Built from a generate loop in the top.

## Test plan
Defaults: N=4, WIDTH=16; cycle numbers are edges after the first accepted beat.
- Reset: hold `nreset` low 3 cycles with `start`=1 and `in_valid`=1 -> all outputs 0 and the state stays IDLE.
- Basic run: `k_len`=3, slices {1,2,3,4}, {5,6,7,8}, {9,10,11,12} gap-free -> lane0 shows 1,5,9 in cycles 1-3; lane3 shows 4,8,12 in cycles 4-6; `done` in cycle 6; `out_active` low elsewhere.
- Bubble: same run with `in_valid`=0 for one cycle after the first slice -> every lane shows a zero slot with `out_active`=0; `done` arrives one cycle later; `err_underrun`=1 if the macro is defined, else 0.
- Zero-length run: `k_len`=0 -> `in_ready` never rises and `done` pulses 2 cycles after `start`.
- Start handling: `start` during STREAM -> ignored and `remain` unaffected; `start` in the cycle after `done` -> new run begins.
- Reset mid-FLUSH: assert `nreset` low for one edge -> next cycle `out_data`=0, `out_active`=0, `busy`=0, and no `done` pulse.
